// File: rtl/can_rx_fifo.sv
// Receive message FIFO: buffers accepted CAN frames (4 x 32-bit words each),
// presents the oldest frame to the register read MUX and raises RX event flags.
module can_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              rx_frame_valid,
  input  logic [31:0]       rx_id,
  input  logic [31:0]       rx_dlc,
  input  logic [31:0]       rx_dw1,
  input  logic [31:0]       rx_dw2,
  input  logic              DEMUX2rxfifo_rd,
  input  logic              DEMUX2rxfifo_flush,
  input  logic [ADDR_W-1:0] DEMUX2rxfifo_wm,
  output logic [31:0]       rxfifo2MUX_id,
  output logic [31:0]       rxfifo2MUX_dlc,
  output logic [31:0]       rxfifo2MUX_dw1,
  output logic [31:0]       rxfifo2MUX_dw2,
  output logic [ADDR_W:0]   rxfifo2MUX_fill,
  output logic              RXOK,
  output logic              RXNEMP,
  output logic              RXOFLW,
  output logic              RXUFLW,
  output logic              RXFLL,
  output logic              RXWM
);

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  logic [31:0] mem_id  [DEPTH];
  logic [31:0] mem_dlc [DEPTH];
  logic [31:0] mem_dw1 [DEPTH];
  logic [31:0] mem_dw2 [DEPTH];

  logic [ADDR_W-1:0] wp;
  logic [ADDR_W-1:0] rp;
  logic [ADDR_W:0]   cnt;
  logic              active;
  logic              pop_ok;
  logic              push_ok;

  // A full FIFO still accepts a push when a valid pop frees the head slot in the same cycle.
  always_comb begin
    active  = !sys_rst && !DEMUX2rxfifo_flush;
    pop_ok  = active && DEMUX2rxfifo_rd && (cnt != '0);
    push_ok = active && rx_frame_valid && ((cnt != FULL) || pop_ok);
  end

  always_ff @(posedge sys_clk) begin
    if (push_ok) begin
      mem_id[wp]  <= rx_id;
      mem_dlc[wp] <= rx_dlc;
      mem_dw1[wp] <= rx_dw1;
      mem_dw2[wp] <= rx_dw2;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst || DEMUX2rxfifo_flush) begin
      wp     <= '0;
      rp     <= '0;
      cnt    <= '0;
      RXOK   <= 1'b0;
      RXOFLW <= 1'b0;
      RXUFLW <= 1'b0;
    end else begin
      if (push_ok) wp <= wp + ADDR_W'(1);
      if (pop_ok)  rp <= rp + ADDR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + (ADDR_W+1)'(1);
        2'b01:   cnt <= cnt - (ADDR_W+1)'(1);
        default: cnt <= cnt;
      endcase
      RXOK   <= push_ok;
      RXOFLW <= rx_frame_valid && !push_ok;
      RXUFLW <= DEMUX2rxfifo_rd && (cnt == '0);
    end
  end

  assign rxfifo2MUX_id   = mem_id[rp];
  assign rxfifo2MUX_dlc  = mem_dlc[rp];
  assign rxfifo2MUX_dw1  = mem_dw1[rp];
  assign rxfifo2MUX_dw2  = mem_dw2[rp];
  assign rxfifo2MUX_fill = cnt;
  assign RXNEMP          = (cnt != '0);
  assign RXFLL           = (cnt == FULL);
  assign RXWM            = (cnt > {1'b0, DEMUX2rxfifo_wm});

endmodule

// File: tb/tb_can_rx_fifo.sv
// Scoreboard bench for can_rx_fifo: a queue-based frame model predicts each
// cycle's outputs, and a negedge monitor compares them against the DUT.
module tb_can_rx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              valid = 1'b0;
  logic [31:0]       id = '0, dlc = '0, dw1 = '0, dw2 = '0;
  logic              rd = 1'b0;
  logic              flush = 1'b0;
  logic [ADDR_W-1:0] wm = '0;
  logic [31:0]       h_id, h_dlc, h_dw1, h_dw2;
  logic [ADDR_W:0]   fill;
  logic              rxok, rxnemp, rxoflw, rxuflw, rxfll, rxwm;

  always #5 clk = ~clk;

  can_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .sys_clk(clk), .sys_rst(rst), .rx_frame_valid(valid),
    .rx_id(id), .rx_dlc(dlc), .rx_dw1(dw1), .rx_dw2(dw2),
    .DEMUX2rxfifo_rd(rd), .DEMUX2rxfifo_flush(flush), .DEMUX2rxfifo_wm(wm),
    .rxfifo2MUX_id(h_id), .rxfifo2MUX_dlc(h_dlc), .rxfifo2MUX_dw1(h_dw1),
    .rxfifo2MUX_dw2(h_dw2), .rxfifo2MUX_fill(fill),
    .RXOK(rxok), .RXNEMP(rxnemp), .RXOFLW(rxoflw), .RXUFLW(rxuflw),
    .RXFLL(rxfll), .RXWM(rxwm)
  );

  typedef struct {
    logic         ok, oflw, uflw;
    int           fill;
    logic [127:0] head;
    logic [ADDR_W-1:0] wm;
  } exp_t;

  logic [127:0] model_q[$];
  exp_t         sb[$];
  int           n_chk = 0;
  int           n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: one expectation per cycle, checked on the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("RXOK",   128'(rxok),   128'(e.ok));
      chk("RXOFLW", 128'(rxoflw), 128'(e.oflw));
      chk("RXUFLW", 128'(rxuflw), 128'(e.uflw));
      chk("fill",   128'(fill),   128'(e.fill));
      chk("RXNEMP", 128'(rxnemp), 128'(e.fill != 0));
      chk("RXFLL",  128'(rxfll),  128'(e.fill == DEPTH));
      chk("RXWM",   128'(rxwm),   128'(e.fill > int'(e.wm)));
      if (e.fill > 0) chk("head", {h_id, h_dlc, h_dw1, h_dw2}, e.head);
    end
  end

  // Drive one cycle of stimulus and record what the model says should follow.
  task automatic step(input logic v, input logic [127:0] f, input logic p,
                      input logic fl, input logic r, input logic [ADDR_W-1:0] w);
    exp_t e;
    logic pop_v, push_v;
    @(negedge clk);
    #1;
    valid = v; {id, dlc, dw1, dw2} = f; rd = p; flush = fl; rst = r; wm = w;
    e.ok = 1'b0; e.oflw = 1'b0; e.uflw = 1'b0; e.wm = w; e.head = '0;
    if (r || fl) begin
      model_q.delete();
    end else begin
      pop_v  = p && (model_q.size() > 0);
      e.uflw = p && (model_q.size() == 0);
      push_v = v && ((model_q.size() < DEPTH) || pop_v);
      e.ok   = push_v;
      e.oflw = v && !push_v;
      if (pop_v)  void'(model_q.pop_front());
      if (push_v) model_q.push_back(f);
    end
    e.fill = model_q.size();
    if (e.fill > 0) e.head = model_q[0];
    sb.push_back(e);
  endtask

  function automatic logic [127:0] frm(input logic [31:0] fid, input logic [31:0] fdw1);
    return {fid, $urandom(), fdw1, $urandom()};
  endfunction

  logic [3:0] cur_wm = 4'd15;

  task automatic push(input logic [127:0] f);
    step(1'b1, f, 1'b0, 1'b0, 1'b0, cur_wm);
  endtask
  task automatic pop();
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, cur_wm);
  endtask
  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, cur_wm);
  endtask

  initial begin
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, cur_wm);
    step(1'b1, frm(32'h55, 0), 1'b1, 1'b0, 1'b1, cur_wm);
    idle();

    for (int i = 0; i < 3; i++) push(frm(32'h100 + 32'(i), 0));
    for (int i = 0; i < 3; i++) pop();

    for (int i = 0; i < DEPTH; i++) push(frm(32'h200 + 32'(i), 32'(i)));
    push(frm(32'h2FF, 0));
    idle();
    step(1'b1, frm(32'h300, 0), 1'b1, 1'b0, 1'b0, cur_wm);
    for (int i = 0; i < DEPTH; i++) pop();
    pop();
    step(1'b1, frm(32'h400, 0), 1'b1, 1'b0, 1'b0, cur_wm);
    pop();

    push(frm(32'h500, 32'd0));
    for (int i = 1; i <= 40; i++)
      step(1'b1, frm(32'h500, 32'(i)), 1'b1, 1'b0, 1'b0, cur_wm);
    pop();

    cur_wm = 4'd3;
    for (int i = 0; i < 4; i++) push(frm(32'h600 + 32'(i), 0));
    pop();
    for (int i = 0; i < 3; i++) pop();
    cur_wm = 4'd15;

    for (int i = 0; i < 5; i++) push(frm(32'h700 + 32'(i), 0));
    step(1'b1, frm(32'h7FF, 0), 1'b0, 1'b1, 1'b0, cur_wm);
    pop();

    for (int i = 0; i < 3; i++) push(frm(32'h800 + 32'(i), 0));
    step(1'b1, frm(32'h8FF, 0), 1'b1, 1'b0, 1'b1, cur_wm);
    idle();

    for (int i = 0; i < 500; i++) begin
      logic [ADDR_W-1:0] w;
      w = ADDR_W'($urandom_range(0, DEPTH - 1));
      step($urandom_range(0, 99) < 55, {$urandom(), $urandom(), $urandom(), $urandom()},
           $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 2,
           $urandom_range(0, 199) < 1, w);
    end
    idle();

    @(negedge clk);
    @(negedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/can_rx_fifo.md
# can_rx_fifo

Receive message FIFO between the CAN protocol engine's receive path and the register interface. It buffers complete received frames and presents the oldest frame to the register read MUX. It also generates the RX event flags (RXOK, RXNEMP, RXOFLW, RXUFLW) consumed by interrupt control. Pushes come from the bit-stream/acceptance stage; pops and flushes come from the register DEMUX.

## Interface

Parameters:
- DEPTH, 16, number of frame entries; power of two, 2..64
- ADDR_W, 4, log2(DEPTH)

Ports:
- sys_clk  in  1  system clock; all logic on rising edge
- sys_rst  in  1  synchronous, active-high reset
- rx_frame_valid  in  1  one-cycle push strobe; frame words below valid in the same cycle
- rx_id  in  32  frame word 0: identifier, IDE, RTR
- rx_dlc  in  32  frame word 1: DLC[31:28], timestamp[15:0]
- rx_dw1  in  32  frame word 2: data bytes 0-3
- rx_dw2  in  32  frame word 3: data bytes 4-7
- DEMUX2rxfifo_rd  in  1  one-cycle pop strobe for the head frame
- DEMUX2rxfifo_flush  in  1  one-cycle clear of all entries
- DEMUX2rxfifo_wm  in  ADDR_W  fill watermark threshold
- rxfifo2MUX_id / _dlc / _dw1 / _dw2  out  32 each  head frame words
- rxfifo2MUX_fill  out  ADDR_W+1  current entry count, 0..DEPTH
- RXOK  out  1  pulse: frame accepted
- RXNEMP  out  1  level: fill != 0
- RXOFLW  out  1  pulse: frame dropped because FIFO full
- RXUFLW  out  1  pulse: pop attempted while empty
- RXFLL  out  1  level: fill == DEPTH
- RXWM  out  1  level: fill > DEMUX2rxfifo_wm

## Operation

- Storage: DEPTH x 128-bit array (4 words per entry), with write pointer wp and read pointer rp (ADDR_W bits each, modulo DEPTH wrap) and count cnt (ADDR_W+1 bits).
- Per-cycle priority:
  1. sys_rst
  2. DEMUX2rxfifo_flush
  3. Push/pop evaluation
- Reset and flush: wp=rp=cnt=0 and all pulse outputs are 0. During a flush, any push is dropped with no RXOK or RXOFLW, and any pop has no effect and no RXUFLW. Array contents are not cleared.
- Push: evaluated against cnt at the start of the cycle.
  - If cnt<DEPTH, or cnt==DEPTH with a valid pop in the same cycle: write the frame at wp, wp+1, pulse RXOK.
  - If cnt==DEPTH and there is no pop: the frame is discarded, wp and cnt are unchanged, RXOFLW pulses. The stored frames are never overwritten.
- Pop:
  - If cnt>0: rp+1, pulse nothing.
  - If cnt==0: RXUFLW pulses and rp is unchanged. This applies even when a push lands in the same cycle; that pushed frame still enters and cnt becomes 1.
- cnt update: +1 on an accepted push only, -1 on a valid pop only, unchanged on both or neither.
- Head outputs: rxfifo2MUX_* = array[rp], combinational from registered storage. When cnt==0 the head outputs are don't-care; the bench must not check them.
- Levels: RXNEMP, RXFLL and RXWM are decoded from the registered cnt. RXWM uses an unsigned compare against the live DEMUX2rxfifo_wm.

## Timing

- Reset values: cnt=0, rxfifo2MUX_fill=0, RXNEMP=0, RXFLL=0, RXOK=0, RXOFLW=0, RXUFLW=0. RXWM=0 because cnt=0 is never > wm.
- Pulses (RXOK, RXOFLW, RXUFLW) are registered. Each is high for exactly the one cycle after the triggering edge, and each pulses once per triggering strobe.
- Push latency: with a frame presented at edge N, cnt, RXNEMP and the head words (if the FIFO was empty) are valid after edge N. RXOK is high from edge N to edge N+1.
- Pop latency: after the pop edge, the next frame is on rxfifo2MUX_* and cnt has decremented.
- Full throughput: one push and one pop per cycle are sustained with no bubbles.
- Reset mid-operation: all state returns to the reset values on that edge, and any push or pop in that cycle is ignored.

## Test plan

- Reset, then push frames with rx_id=0x100..0x102 on consecutive cycles, then pop three times:
  - RXOK pulses 3 times and fill goes 1,2,3.
  - Head reads 0x100, 0x101, 0x102.
  - fill returns to 0 and RXNEMP falls after the third pop.
- Fill to DEPTH=16:
  - RXFLL=1.
  - A 17th push pulses RXOFLW once with no RXOK; fill stays 16 and the head is still the first frame.
  - Push+pop in the same cycle while full: RXOK pulses, fill stays 16, and the new frame appears last after 16 pops.
- Pop on empty: RXUFLW pulses once and fill stays 0. Push+pop on empty: RXUFLW plus RXOK, fill=1, head = pushed frame.
- Wrap-around: 40 push/pop pairs with incrementing rx_dw1 pass through wp/rp wrap, and every popped word matches in order.
- Set DEMUX2rxfifo_wm=3 and push 4 frames: RXWM rises after the 4th push and falls after 1 pop.
- With fill=5, assert flush together with a push: fill=0, no RXOK, no RXOFLW, RXNEMP=0.
- Assert sys_rst mid-burst: fill=0 and all flags are 0 on the next cycle.
